// File: rtl/pdiv_pkg.sv
// pdiv_pkg -- shared FSM encodings and step-counter sizing for the pdiv divider.
// Rev 1.0
`default_nettype none

package pdiv_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdiv_negate.sv
// pdiv_negate -- conditional two's-complement negate.
// Rev 1.0
`default_nettype none

module pdiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign o_val = i_neg ? (~i_val + C_ONE) : i_val;

endmodule

`default_nettype wire

// File: rtl/pdiv.sv
// pdiv -- multicycle radix-2 restoring divider, signed/unsigned, with divide-by-zero flag.
// Rev 1.0
`default_nettype none

module pdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  import pdiv_pkg::*;

  localparam int             CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_STEPS   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_neg_a;
  logic             r_neg_q;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz_out;
  logic             r_done;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_a_neg  = sign & a[WIDTH-1];
  assign w_b_neg  = sign & b[WIDTH-1];
  assign w_b_zero = (b == '0);

  pdiv_negate #(.WIDTH(WIDTH)) u_neg_a (.i_neg(w_a_neg), .i_val(a), .o_val(w_a_mag));
  pdiv_negate #(.WIDTH(WIDTH)) u_neg_b (.i_neg(w_b_neg), .i_val(b), .o_val(w_b_mag));
  pdiv_negate #(.WIDTH(WIDTH)) u_fix_q (.i_neg(r_neg_q), .i_val(r_quo), .o_val(w_q_fix));
  pdiv_negate #(.WIDTH(WIDTH)) u_fix_r (.i_neg(r_neg_a), .i_val(r_rem), .o_val(w_r_fix));

  // Partial remainder is always < divisor, so the shifted value fits in WIDTH+1 bits.
  assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
  assign w_fit   = ~w_trial[WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_dz     <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_dz_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem <= '0;
            if (w_b_zero) begin
              // Raw dividend parked in r_quo so FIX can return it as the remainder.
              r_quo   <= a;
              r_div   <= '0;
              r_neg_a <= 1'b0;
              r_neg_q <= 1'b0;
              r_dz    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_FIX;
            end else begin
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_neg_a <= w_a_neg;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_dz    <= 1'b0;
              r_cnt   <= C_STEPS;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (w_fit) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_dz) begin
            r_q <= '1;
            r_r <= r_quo;
          end else begin
            r_q <= w_q_fix;
            r_r <= w_r_fix;
          end
          r_dz_out <= r_dz;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign dz   = r_dz_out;

endmodule

`default_nettype wire

// File: tb/tb_pdiv.sv
// tb_pdiv -- self-checking bench for pdiv: reference model built on $signed / and %.
// Rev 1.0
`default_nettype none

module tb_pdiv;

  localparam int W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pdiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
  );

  function automatic void ref_div(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
    edz = 1'b0;
    if (y == '0) begin
      eq = '1; er = x; edz = 1'b1;
    end else if (s) begin
      if (x == MIN && y == '1) begin
        eq = MIN; er = '0;
      end else begin
        eq = W'($signed(x) / $signed(y));
        er = W'($signed(x) % $signed(y));
      end
    end else begin
      eq = x / y; er = x % y;
    end
  endfunction

  task automatic chkw(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Model: tracks remaining busy cycles and the result due at completion.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge clk or negedge rst) begin : model
    logic [W-1:0] tq, tr;
    logic         tdz;
    if (!rst) begin
      m_left <= 0; m_done <= 1'b0;
      m_q <= '0; m_r <= '0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
        end
      end else if (start) begin
        ref_div(sign, a, b, tq, tr, tdz);
        p_q <= tq; p_r <= tr; p_dz <= tdz;
        m_left <= (b == '0) ? 1 : W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk1("cyc busy", busy, m_left > 0);
      chk1("cyc done", done, m_done);
      chkw("cyc q", q, m_q);
      chkw("cyc r", r, m_r);
      chk1("cyc dz", dz, m_dz);
    end
  end

  task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; sign = s; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    sign = 1'($urandom_range(0, 1)); a = $urandom; b = $urandom;
  endtask

  task automatic finish_op(input string nm, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input int ebusy);
    int cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chkw({nm, " busy cycles"}, W'(cyc), W'(ebusy));
    chk1({nm, " done"}, done, 1'b1);
    chkw({nm, " q"}, q, eq);
    chkw({nm, " r"}, r, er);
    chk1({nm, " dz"}, dz, edz);
  endtask

  initial begin
    logic [W-1:0] x, y, eq, er;
    logic         s, edz;
    int           seen;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chkw("reset q", q, '0);
    chkw("reset r", r, '0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset dz", dz, 1'b0);
    chk_en = 1'b1;

    launch(1'b1, 32'hFFFF_FFF0, 32'h0000_0005);
    finish_op("s -16/5", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    launch(1'b0, 32'hFFFF_FFF0, 32'h0000_0005);
    finish_op("u big/5", 32'h3333_3330, 32'h0000_0000, 1'b0, 33);
    launch(1'b1, 32'd26, 32'd0);
    finish_op("div zero", 32'hFFFF_FFFF, 32'h0000_001A, 1'b1, 1);
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("overflow", 32'h8000_0000, 32'h0000_0000, 1'b0, 33);
    launch(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFE);
    finish_op("back2back", 32'h0000_8000, 32'h0000_0000, 1'b0, 33);

    // Second start lands in busy cycle 5 and must be dropped.
    launch(1'b1, 32'h0000_FFFF, 32'hFFFF_0000);
    repeat (4) @(negedge clk);
    start = 1'b1; sign = 1'b0; a = 32'd1; b = 32'd15;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignored start", 32'h0000_0000, 32'h0000_FFFF, 1'b0, 28);

    launch(1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst done", done, 1'b0);
    chkw("async rst q", q, '0);
    chkw("async rst r", r, '0);
    chk1("async rst dz", dz, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chkw("no done after abort", W'(seen), '0);
    launch(1'b1, 32'd26, 32'd5);
    finish_op("after reset", 32'd5, 32'd1, 1'b0, 33);

    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       y = '1;
        2:       y = W'($urandom_range(1, 15));
        3:       begin x = MIN; y = $urandom; end
        4:       y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      ref_div(s, x, y, eq, er, edz);
      launch(s, x, y);
      finish_op("random", eq, er, edz, (y == '0) ? 1 : W + 1);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
